// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: arbiter state/owner encodings and bus widths
package cpu_pkg;

  localparam int CPU_AW = 32;
  localparam int CPU_DW = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_ACC  = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-input round-robin picker for the memory arbiter
module mem_arb_rr
  import cpu_pkg::*;
(
  input  logic req_if,
  input  logic req_d,
  input  logic last_owner,
  output logic gnt_valid,
  output logic gnt_owner
);

  always_comb begin
    gnt_valid = req_if | req_d;
    // On a tie the port that did not own the previous access wins.
    if (req_if && req_d)
      gnt_owner = ~last_owner;
    else if (req_d)
      gnt_owner = OWN_D;
    else
      gnt_owner = OWN_IF;
  end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - fetch/data arbiter and fixed-latency sequencer for the unified memory
module mem_arb
  import cpu_pkg::*;
#(
  parameter int AW  = CPU_AW,
  parameter int DW  = CPU_DW,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  arb_state_t state;
  logic [3:0] cnt;
  logic       owner;
  logic       last_owner;
  logic       gnt_valid;
  logic       gnt_owner;

  mem_arb_rr u_rr (
    .req_if     (if_req),
    .req_d      (d_req),
    .last_owner (last_owner),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state      <= ARB_IDLE;
      cnt        <= 4'd0;
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt_valid) begin
            owner     <= gnt_owner;
            mem_en    <= 1'b1;
            mem_we    <= (gnt_owner == OWN_D) && d_we;
            mem_addr  <= (gnt_owner == OWN_D) ? d_addr : if_addr;
            mem_wdata <= (gnt_owner == OWN_D) ? d_wdata : '0;
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
            state     <= ARB_ACC;
          end
        end
        ARB_ACC: begin
          // mem_we still holds the latched direction of this access.
          if (cnt == 4'd0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= ARB_RESP;
            if (owner == OWN_D) begin
              d_done <= 1'b1;
              if (!mem_we)
                d_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ARB_RESP: begin
          if_done    <= 1'b0;
          d_done     <= 1'b0;
          last_owner <= owner;
          busy       <= 1'b0;
          state      <= ARB_IDLE;
        end
        default: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          if_done <= 1'b0;
          d_done  <= 1'b0;
          busy    <= 1'b0;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb (LAT=2 main instance, LAT=1 and LAT=15 latency instances)
module tb_mem_arb;

  logic        clk;
  logic        Reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, d_done, mem_en, mem_we, busy;

  int total = 0;
  int bad   = 0;

  mem_arb #(.AW(32), .DW(32), .LAT(2)) dut (
    .clk(clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Latency-only instances: data port loads, read data is a function of the address.
  logic        r1_d_req, r15_d_req, r_if_req, r_d_we;
  logic [31:0] r1_d_addr, r15_d_addr, r_if_addr, r_wdata;
  logic [31:0] r1_if_rdata, r1_d_rdata, r1_mem_addr, r1_mem_wdata, r1_mem_rdata;
  logic [31:0] r15_if_rdata, r15_d_rdata, r15_mem_addr, r15_mem_wdata, r15_mem_rdata;
  logic        r1_if_done, r1_d_done, r1_mem_en, r1_mem_we, r1_busy;
  logic        r15_if_done, r15_d_done, r15_mem_en, r15_mem_we, r15_busy;

  assign r1_mem_rdata  = r1_mem_addr ^ 32'hA5A5_0000;
  assign r15_mem_rdata = r15_mem_addr ^ 32'hA5A5_0000;

  mem_arb #(.AW(32), .DW(32), .LAT(1)) dut_l1 (
    .clk(clk), .Reset(Reset),
    .if_req(r_if_req), .if_addr(r_if_addr), .if_rdata(r1_if_rdata), .if_done(r1_if_done),
    .d_req(r1_d_req), .d_we(r_d_we), .d_addr(r1_d_addr), .d_wdata(r_wdata),
    .d_rdata(r1_d_rdata), .d_done(r1_d_done),
    .mem_en(r1_mem_en), .mem_we(r1_mem_we), .mem_addr(r1_mem_addr), .mem_wdata(r1_mem_wdata),
    .mem_rdata(r1_mem_rdata), .busy(r1_busy)
  );

  mem_arb #(.AW(32), .DW(32), .LAT(15)) dut_l15 (
    .clk(clk), .Reset(Reset),
    .if_req(r_if_req), .if_addr(r_if_addr), .if_rdata(r15_if_rdata), .if_done(r15_if_done),
    .d_req(r15_d_req), .d_we(r_d_we), .d_addr(r15_d_addr), .d_wdata(r_wdata),
    .d_rdata(r15_d_rdata), .d_done(r15_d_done),
    .mem_en(r15_mem_en), .mem_we(r15_mem_we), .mem_addr(r15_mem_addr), .mem_wdata(r15_mem_wdata),
    .mem_rdata(r15_mem_rdata), .busy(r15_busy)
  );

  // Memory model: written words override a fixed initial image.
  logic [31:0] mem [0:63];
  logic [63:0] wr_v = '0;

  function automatic logic [31:0] init_word(input logic [5:0] idx);
    if (idx == 6'd1) return 32'h8C01_0008;
    if (idx == 6'd2) return 32'h1234_5678;
    return {16'h0BAD, 10'd0, idx};
  endfunction

  assign mem_rdata = wr_v[mem_addr[7:2]] ? mem[mem_addr[7:2]] : init_word(mem_addr[7:2]);

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[7:2]]  <= mem_wdata;
      wr_v[mem_addr[7:2]] <= 1'b1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[8];

  task automatic run_access(input vec_t v);
    int          done_cyc = 0;
    int          en_cyc = 0;
    int          we_cyc = 0;
    int          other = 0;
    logic [31:0] addr_seen = '0;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int k = 1; k <= 20 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cyc++;
        if (en_cyc == 1) addr_seen = mem_addr;
      end
      if (mem_we) we_cyc++;
      if (v.is_d ? if_done : d_done) other++;
      if (v.is_d ? d_done : if_done) begin
        done_cyc = k;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      end
    end
    chk("latency", done_cyc, 3);
    chk("en_cycles", en_cyc, 2);
    chk("we_cycles", we_cyc, v.we ? 2 : 0);
    chk("mem_addr", addr_seen, v.addr);
    chk("other_done", other, 0);
    chk("if_rdata", if_rdata, v.exp_if);
    chk("d_rdata", d_rdata, v.exp_d);
    @(negedge clk);
    chk("busy_after", {31'd0, busy}, 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    if (if_done | d_done) chk("done_after", 32'd1, 32'd0);
  endtask

  initial begin
    int          seq[4];
    int          tcyc[4];
    int          n;
    int          l1, l15;
    int          cnt_hi;
    logic [31:0] l1_rd, l15_rd;

    vecs[0] = '{1'b0, 1'b0, 32'h04, 32'h0,         32'h8C01_0008, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h8C01_0008, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h8C01_0008, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h08, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b1, 32'h14, 32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h14, 32'h0,         32'h1234_5678, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 1'b0, 32'h04, 32'h0,         32'h1234_5678, 32'h8C01_0008};
    vecs[7] = '{1'b0, 1'b0, 32'h14, 32'h0,         32'hCAFE_F00D, 32'h8C01_0008};

    Reset = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    r1_d_req = 1'b0; r15_d_req = 1'b0; r_if_req = 1'b0; r_d_we = 1'b0;
    r1_d_addr = '0; r15_d_addr = '0; r_if_addr = '0; r_wdata = '0;

    // Reset held three cycles, then idle with no requests.
    repeat (3) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_d_done", {31'd0, d_done}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    cnt_hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy | mem_en) cnt_hi++;
    end
    chk("idle_stays", cnt_hi, 0);

    for (int i = 0; i < 8; i++) run_access(vecs[i]);

    // Round robin from reset: both held high, expect D, IF, D, IF every LAT+2 cycles.
    Reset = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h04;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08;
    n = 0;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(negedge clk);
      if (if_done && d_done) chk("both_done", 32'd1, 32'd0);
      else if (if_done || d_done) begin
        seq[n] = d_done ? 1 : 0;
        tcyc[n] = k;
        n++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("rr_count", n, 4);
    if (n == 4) begin
      chk("rr_0", seq[0], 1);
      chk("rr_1", seq[1], 0);
      chk("rr_2", seq[2], 1);
      chk("rr_3", seq[3], 0);
      chk("rr_first_lat", tcyc[0], 3);
      chk("rr_gap", tcyc[3] - tcyc[0], 12);
    end
    @(negedge clk);

    // Reset during the first ACC cycle of a store.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h0000_0055;
    @(negedge clk);
    chk("abort_we_before", {31'd0, mem_we}, 32'd1);
    Reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("abort_we", {31'd0, mem_we}, 32'd0);
    chk("abort_en", {31'd0, mem_en}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    Reset = 1'b1;
    cnt_hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (d_done | busy) cnt_hi++;
    end
    chk("abort_no_done", cnt_hi, 0);

    // LAT=1 and LAT=15 single loads launched on the same edge.
    r1_d_addr = 32'h40; r15_d_addr = 32'h44;
    r1_d_req = 1'b1; r15_d_req = 1'b1;
    l1 = 0; l15 = 0; l1_rd = '0; l15_rd = '0;
    for (int k = 1; k <= 30 && (l1 == 0 || l15 == 0); k++) begin
      @(negedge clk);
      if (r1_d_done && l1 == 0) begin
        l1 = k; l1_rd = r1_d_rdata; r1_d_req = 1'b0;
      end
      if (r15_d_done && l15 == 0) begin
        l15 = k; l15_rd = r15_d_rdata; r15_d_req = 1'b0;
      end
    end
    r1_d_req = 1'b0; r15_d_req = 1'b0;
    chk("lat1_done", l1, 2);
    chk("lat15_done", l15, 16);
    chk("lat1_rdata", l1_rd, 32'hA5A5_0040);
    chk("lat15_rdata", l15_rd, 32'hA5A5_0044);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
